pattern_scheduler: RTL and testbench



---
 rtl/pattern_pkg.sv | 31 +++
 rtl/pattern_scheduler_frame_rate_div.sv | 40 ++++
 rtl/pattern_scheduler.sv | 118 +++++++++++
 tb/tb_pattern_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared constants for the VGA pattern path: scheduler states, speed codes,
// generator indices and the RGB channel width.
package pattern_pkg;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   typedef logic [1:0] speed_t;

   localparam speed_t SPD_1     = 2'd0;
   localparam speed_t SPD_2     = 2'd1;
   localparam speed_t SPD_4     = 2'd2;
   localparam speed_t SPD_PAUSE = 2'd3;

   localparam logic [2:0] PAT_CHECKER  = 3'd0;
   localparam logic [2:0] PAT_BARS     = 3'd1;
   localparam logic [2:0] PAT_GRADIENT = 3'd2;
   localparam logic [2:0] PAT_GRID     = 3'd3;

   localparam int unsigned RGB_W = 6;

   // Bits of the frame divider that are live for a given speed code.
   function automatic logic [1:0] speed_mask(input speed_t spd);
      case (spd)
         SPD_1:   speed_mask = 2'b00;
         SPD_2:   speed_mask = 2'b01;
         default: speed_mask = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/pattern_scheduler_frame_rate_div.sv
// Frame-rate divider: emits an advance strobe on every 1st/2nd/4th enabled
// frame tick, or never while paused.
module frame_rate_div
   import pattern_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   tick_i,
   input  speed_t speed_i,
   input  logic   en_i,
   input  logic   clr_i,
   output logic   adv_o
);

   logic [1:0] div_q;
   logic [1:0] div_d;
   logic [1:0] div_m;

   // Masking by the current speed lets a rate change take effect on the very next tick.
   always_comb begin
      div_m = div_q & speed_mask(speed_i);
      div_d = div_q;
      adv_o = 1'b0;
      if (clr_i) begin
         div_d = '0;
      end else if (en_i && tick_i && (speed_i != SPD_PAUSE)) begin
         adv_o = (div_m == 2'd0);
         div_d = (div_m + 2'd1) & speed_mask(speed_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-level controller selecting the active pattern generator, issuing
// advance pulses and blanking the screen across pattern switches.
module pattern_scheduler
   import pattern_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS = 4,
   parameter int unsigned DWELL_FRAMES = 240,
   parameter int unsigned BLANK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       btn_next,
   input  logic       auto_en,
   input  logic [1:0] speed,
   output logic       next_frame,
   output logic [2:0] pattern_sel,
   output logic       blank
);

   localparam int unsigned DW = $clog2(DWELL_FRAMES);
   localparam int unsigned BW = $clog2(BLANK_FRAMES + 1);

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
   localparam logic [BW-1:0] BLANK_ONE  = BW'(1);
   localparam logic [2:0]    PAT_LAST   = 3'(NUM_PATTERNS - 1);

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [2:0]    pat_q, pat_d;
   logic          pend_q, pend_d;
   logic          btn_q;
   logic          nf_q;
   logic          blank_q, blank_d;

   logic frame_tick;
   logic btn_edge;
   logic run;
   logic switch_req;
   logic adv;

   assign frame_tick = (x == 10'd0) && (y == 10'd0);
   assign btn_edge   = btn_next & ~btn_q;
   assign run        = (state_q == ST_RUN);
   assign switch_req = pend_q | btn_edge | (auto_en && (dwell_q == DWELL_LAST));

   frame_rate_div u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (frame_tick),
      .speed_i (speed),
      .en_i    (run & ~switch_req),
      .clr_i   (~run),
      .adv_o   (adv)
   );

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      bcnt_d  = bcnt_q;
      pat_d   = pat_q;
      pend_d  = pend_q | btn_edge;
      if (run) begin
         if (frame_tick) begin
            if (switch_req) begin
               pat_d   = (pat_q == PAT_LAST) ? 3'd0 : pat_q + 3'd1;
               pend_d  = 1'b0;
               dwell_d = '0;
               bcnt_d  = '0;
               state_d = ST_BLANK;
            end else if (dwell_q != DWELL_LAST) begin
               dwell_d = dwell_q + DWELL_ONE;
            end
         end
      end else begin
         dwell_d = '0;
         if (frame_tick) begin
            if (bcnt_q == BLANK_LAST) begin
               state_d = ST_RUN;
            end else begin
               bcnt_d = bcnt_q + BLANK_ONE;
            end
         end
      end
      blank_d = (state_d == ST_BLANK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         dwell_q <= '0;
         bcnt_q  <= '0;
         pat_q   <= '0;
         pend_q  <= 1'b0;
         btn_q   <= 1'b0;
         nf_q    <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         bcnt_q  <= bcnt_d;
         pat_q   <= pat_d;
         pend_q  <= pend_d;
         btn_q   <= btn_next;
         nf_q    <= adv;
         blank_q <= blank_d;
      end
   end

   assign next_frame  = nf_q;
   assign pattern_sel = pat_q;
   assign blank       = blank_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler on a 16x8 raster, comparing every
// cycle against a frame-level reference model plus directed scenario checks.
module tb_pattern_scheduler;

   localparam int NUM   = 4;
   localparam int DWELL = 4;
   localparam int BLANK = 2;
   localparam int XW    = 16;
   localparam int YH    = 8;
   localparam int FRAME = XW * YH;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       btn_next = 1'b0;
   logic       auto_en = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       next_frame;
   logic [2:0] pattern_sel;
   logic       blank;

   always #5 clk = ~clk;

   pattern_scheduler #(
      .NUM_PATTERNS (NUM),
      .DWELL_FRAMES (DWELL),
      .BLANK_FRAMES (BLANK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .btn_next    (btn_next),
      .auto_en     (auto_en),
      .speed       (speed),
      .next_frame  (next_frame),
      .pattern_sel (pattern_sel),
      .blank       (blank)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: frame-level bookkeeping of what the screen should show.
   int m_pat, m_pend, m_shown, m_blank_left, m_phase, m_nf, m_btn;
   int nf_cnt;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pat = 0; m_pend = 0; m_shown = 0; m_blank_left = 0;
      m_phase = 0; m_nf = 0; m_btn = 0;
   endtask

   task automatic model_step();
      int edge_seen;
      int period;
      edge_seen = (btn_next && !m_btn) ? 1 : 0;
      m_btn = btn_next;
      m_nf = 0;
      if (x == 0 && y == 0) begin
         if (m_blank_left > 0) begin
            m_blank_left--;
            if (m_blank_left == 0) m_phase = 0;
            if (edge_seen != 0) m_pend = 1;
         end else if (m_pend != 0 || edge_seen != 0 || (auto_en && m_shown == DWELL - 1)) begin
            m_pat = (m_pat + 1) % NUM;
            m_pend = 0;
            m_shown = 0;
            m_blank_left = BLANK;
         end else begin
            if (m_shown < DWELL - 1) m_shown++;
            if (speed != 2'd3) begin
               period = 1 << speed;
               m_phase = m_phase % period;
               m_nf = (m_phase == 0) ? 1 : 0;
               m_phase = (m_phase + 1) % period;
            end
         end
      end else if (edge_seen != 0) begin
         m_pend = 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
      check_eq("next_frame", int'(next_frame), m_nf);
      check_eq("pattern_sel", int'(pattern_sel), m_pat);
      check_eq("blank", int'(blank), (m_blank_left > 0) ? 1 : 0);
      nf_cnt += int'(next_frame);
      if (x == 10'(XW - 1)) begin
         x = '0;
         y = (y == 10'(YH - 1)) ? '0 : y + 10'd1;
      end else begin
         x = x + 10'd1;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic frames(input int n);
      run_cycles(n * FRAME);
   endtask

   // Leaves the bench so that the next cycle() presents a frame tick.
   task automatic goto_tick();
      for (int k = 0; k < FRAME && !(x == 0 && y == 0); k++) cycle();
   endtask

   task automatic press();
      btn_next = 1'b1;
      cycle();
      btn_next = 1'b0;
      cycle();
   endtask

   task automatic tick_cycle();
      goto_tick();
      cycle();
   endtask

   int rt;
   int p0;
   logic b0;

   initial begin
      model_reset();
      nf_cnt = 0;
      rst_n = 1'b0;
      run_cycles(3);
      x = '0; y = '0;
      rst_n = 1'b1;

      // Free-running advance rates.
      nf_cnt = 0; frames(5); check_eq("t1_pulses", nf_cnt, 5);
      check_eq("t1_pat", int'(pattern_sel), 0);
      speed = 2'd1; nf_cnt = 0; frames(8); check_eq("t2_spd1", nf_cnt, 4);
      speed = 2'd3; nf_cnt = 0; frames(8); check_eq("t2_pause", nf_cnt, 0);
      speed = 2'd2; nf_cnt = 0; frames(8); check_eq("t2_spd4", nf_cnt, 2);

      // Button switch with blanking window.
      speed = 2'd0;
      run_cycles(20);
      press();
      tick_cycle();
      check_eq("t3_sel", int'(pattern_sel), 1);
      check_eq("t3_blank", int'(blank), 1);
      tick_cycle(); check_eq("t3_blank_hold", int'(blank), 1);
      tick_cycle(); check_eq("t3_blank_fall", int'(blank), 0);
      check_eq("t3_nf_quiet", int'(next_frame), 0);
      tick_cycle(); check_eq("t3_nf_first", int'(next_frame), 1);
      run_cycles(10);
      for (int i = 0; i < 3; i++) press();
      frames(4);
      check_eq("t3_triple", int'(pattern_sel), 2);

      // Press during blanking is held until the first RUN tick.
      press();
      tick_cycle(); check_eq("t5_sel", int'(pattern_sel), 3);
      run_cycles(30);
      press();
      check_eq("t5_held", int'(pattern_sel), 3);
      tick_cycle(); check_eq("t5_blank1", int'(blank), 1);
      tick_cycle(); check_eq("t5_run", int'(pattern_sel), 3);
      check_eq("t5_unblank", int'(blank), 0);
      tick_cycle(); check_eq("t5_sel2", int'(pattern_sel), 0);
      check_eq("t5_reblank", int'(blank), 1);
      check_eq("t5_nf", int'(next_frame), 0);

      // Auto dwell wrap from the last pattern.
      frames(3);
      for (int i = 0; i < 8 && m_pat != 2; i++) begin press(); frames(3); end
      press();
      tick_cycle();
      check_eq("t4_at3", int'(pattern_sel), 3);
      auto_en = 1'b1;
      rt = 0;
      for (int i = 0; i < 10; i++) begin
         goto_tick();
         b0 = blank;
         cycle();
         if (!b0) rt++;
         if (pattern_sel != 3'd3) break;
      end
      check_eq("t4_run_ticks", rt, DWELL);
      check_eq("t4_wrap", int'(pattern_sel), 0);
      check_eq("t4_wrap_blank", int'(blank), 1);
      p0 = -1;
      for (int i = 0; i < 12; i++) begin
         goto_tick();
         if (m_blank_left == 0 && m_shown == DWELL - 1) begin
            p0 = int'(pattern_sel);
            btn_next = 1'b1;
            cycle();
            btn_next = 1'b0;
            break;
         end
         cycle();
      end
      auto_en = 1'b0;
      frames(4);
      check_eq("t4_single", int'(pattern_sel), (p0 + 1) % NUM);

      // Randomized mix of presses, speed changes and auto toggling.
      for (int i = 0; i < 30 * FRAME; i++) begin
         if ($urandom_range(0, 149) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 399) == 0) speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) auto_en = ~auto_en;
         cycle();
      end
      btn_next = 1'b0; auto_en = 1'b0; speed = 2'd0;
      frames(4);

      // Asynchronous reset while blanking on pattern 2.
      for (int i = 0; i < 8 && m_pat != 1; i++) begin press(); frames(3); end
      press();
      tick_cycle();
      check_eq("t6_pre_sel", int'(pattern_sel), 2);
      check_eq("t6_pre_blank", int'(blank), 1);
      run_cycles(40);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("t6_async_sel", int'(pattern_sel), 0);
      check_eq("t6_async_blank", int'(blank), 0);
      check_eq("t6_async_nf", int'(next_frame), 0);
      @(negedge clk);
      run_cycles(3);
      x = '0; y = '0;
      rst_n = 1'b1;
      nf_cnt = 0;
      frames(3);
      check_eq("t6_after_sel", int'(pattern_sel), 0);
      check_eq("t6_after_nf", nf_cnt, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
